// File: rtl/aud_pkg.sv
// Shared definitions for the WM8731 audio serial paths (DAC transmit and,
// later, ADC receive): sample width, transmitter state encoding and PCM type.
package aud_pkg;

  localparam int AUD_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LEFT,
    S_GAPL,
    S_RIGHT,
    S_GAPR
  } tx_state_e;

  typedef logic signed [AUD_DATA_W-1:0] sample_t;

  // True while a channel slot is actively shifting bits onto the line.
  function automatic logic is_slot(input tx_state_e s);
    return (s == S_LEFT) || (s == S_RIGHT);
  endfunction

endpackage

// File: rtl/aud_sample_fifo.sv
// Small synchronous sample FIFO with registered occupancy. No bypass path:
// an entry pushed on an edge is poppable from the following edge onwards.
// Shared between the playback and record paths.
module aud_sample_fifo
  import aud_pkg::*;
#(
  parameter int DATA_W     = AUD_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_push,
  input  logic [DATA_W-1:0]                i_data,
  input  logic                             i_pop,
  output logic [DATA_W-1:0]                o_data,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push_ok, pop_ok;

  assign o_full   = (level_q == LW'(FIFO_DEPTH));
  assign o_empty  = (level_q == '0);
  assign push_ok  = i_push && !o_full;
  assign pop_ok   = i_pop && !o_empty;
  assign o_data   = mem_q[rd_q];
  assign o_level  = level_q;

  // Pointer and occupancy next-state; depth is a power of two so the
  // pointers wrap by natural overflow.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Sample storage; contents are only meaningful behind the read pointer.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q] <= i_data;
  end

endmodule

// File: rtl/aud_i2s_tx.sv
// WM8731 DAC serial transmitter. Buffers PCM samples and shifts each one
// MSB-first into the left slot after a DACLRCK falling edge and again into
// the right slot after the rising edge (one FIFO pop per frame).
module aud_i2s_tx
  import aud_pkg::*;
#(
  parameter int DATA_W     = AUD_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_en,
  input  logic                             i_daclrck,
  input  logic [DATA_W-1:0]                i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic                             o_dacdat,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_level,
  output logic                             o_underrun,
  output logic                             o_frame_err
);

  localparam int CW = $clog2(DATA_W);

  tx_state_e                 state_q, state_d;
  logic                      lrc_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]         sh_q, sh_d;
  logic signed [DATA_W-1:0]  sample_q, sample_d;
  logic                      underrun_q, underrun_d;
  logic                      frame_err_q, frame_err_d;

  logic                      fe, re;
  logic                      start_l, start_r;
  logic                      pop;
  logic                      fifo_full, fifo_empty;
  logic [DATA_W-1:0]         fifo_data;

  aud_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_valid),
    .i_data  (i_data),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  assign o_ready     = !fifo_full;
  assign o_underrun  = underrun_q;
  assign o_frame_err = frame_err_q;

  // LR clock edges, seen against the previous-cycle LRCK sample.
  assign fe = !i_daclrck && lrc_q;
  assign re = i_daclrck && !lrc_q;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: slots start only on the matching LRCK edge; an edge that
  // lands inside a busy slot still starts the new slot.
  always_comb begin
    state_d = state_q;
    start_l = 1'b0;
    start_r = 1'b0;
    if (!i_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_WAIT;
        S_WAIT:  if (fe) start_l = 1'b1;
        S_LEFT: begin
          if (re)                 start_r = 1'b1;
          else if (cnt_q == '0)   state_d = S_GAPL;
        end
        S_GAPL:  if (re) start_r = 1'b1;
        S_RIGHT: begin
          if (fe)                 start_l = 1'b1;
          else if (cnt_q == '0)   state_d = S_GAPR;
        end
        S_GAPR:  if (fe) start_l = 1'b1;
        default: state_d = S_IDLE;
      endcase
      if (start_l) state_d = S_LEFT;
      if (start_r) state_d = S_RIGHT;
    end
  end

  // FSM output: the line is quiet outside the two shifting slots.
  always_comb begin
    o_dacdat = 1'b0;
    if (is_slot(state_q)) o_dacdat = sh_q[DATA_W-1];
  end

  // Datapath next state: sample capture, shift, bit counter and status pulses.
  always_comb begin
    sample_d    = sample_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    pop         = start_l && !fifo_empty;
    underrun_d  = start_l && fifo_empty;
    frame_err_d = ((state_q == S_LEFT && start_r) ||
                   (state_q == S_RIGHT && start_l)) && (cnt_q != '0);
    if (start_l) begin
      sample_d = fifo_empty ? '0 : fifo_data;
      sh_d     = fifo_empty ? '0 : fifo_data;
      cnt_d    = CW'(DATA_W-1);
    end else if (start_r) begin
      sh_d     = sample_q;
      cnt_d    = CW'(DATA_W-1);
    end else if (is_slot(state_q) && cnt_q != '0) begin
      sh_d     = {sh_q[DATA_W-2:0], 1'b0};
      cnt_d    = cnt_q - CW'(1);
    end
  end

  // Control registers: LRCK history, bit counter and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q       <= 1'b1;
      cnt_q       <= '0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      lrc_q       <= i_daclrck;
      cnt_q       <= cnt_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Data registers: held sample and shift register (output gated by state).
  always_ff @(posedge i_clk) begin
    sample_q <= sample_d;
    sh_q     <= sh_d;
  end

endmodule
